instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, meaning: PC loaded on reset (word aligned).
REQ-002 Parameter: NOP_INSTR, default 32'hFC00_0000, meaning: bubble word; opcode 6'b111111 decodes to all-zero controls.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Ports, as name, direction, width, meaning:
  clk  in  1  rising-edge clock.
  rst_n  in  1  async active-low reset.
  stall  in  1  downstream cannot accept the presented instruction.
  flush  in  1  abandon current fetch; restart at flush_pc.
  flush_pc  in  32  restart address; bits [1:0] ignored.
  Branch  in  1  decoded branch control for the presented instruction.
  Jump  in  1  decoded jump control for the presented instruction.
  cond  in  1  branch condition from the ALU.
  imem_req  out  1  instruction memory request.
  imem_addr  out  32  request address, equal to PC.
  imem_ack  in  1  memory response strobe, one cycle.
  imem_rdata  in  32  instruction word, valid with imem_ack.
  Instruction  out  32  presented instruction.
  Opcode  out  6  equal to Instruction[31:26], feeds the control unit.
  pc_plus4  out  32  PC of the presented instruction plus 4.
  instr_valid  out  1  Instruction is valid and awaiting consumption.

Function
REQ-005 States SHALL be: RESET_WAIT, REQ, VALID, DRAIN.
REQ-006 RESET_WAIT SHALL last exactly one cycle after rst_n deasserts, then go to REQ.
REQ-007 In REQ: imem_req=1 and imem_addr=PC. On imem_ack: capture imem_rdata into Instruction, set pc_plus4=PC+4, go to VALID.
REQ-008 In VALID: instr_valid=1 and imem_req=0. While stall=1, all outputs SHALL hold.
REQ-009 In VALID with stall=0, the instruction is consumed: PC SHALL load the next PC, Instruction SHALL load NOP_INSTR, instr_valid SHALL go to 0, and the state SHALL go to REQ.
REQ-010 Next-PC priority: Jump=1 gives {pc_plus4[31:28], Instruction[25:0], 2'b00}; else Branch&cond gives pc_plus4 + (signext(Instruction[15:0])<<2); else pc_plus4.
REQ-011 All PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0. PC[1:0] SHALL always be 2'b00.
REQ-012 flush in REQ with no ack in the same cycle: PC=flush_pc, go to DRAIN. In DRAIN: imem_req=0. The next imem_ack SHALL be discarded, then go to REQ.
REQ-013 flush in REQ with imem_ack in the same cycle: discard the data, PC=flush_pc, go to REQ.
REQ-014 flush in VALID or RESET_WAIT: PC=flush_pc, Instruction=NOP_INSTR, go to REQ. flush overrides stall.
REQ-015 flush in DRAIN: PC=flush_pc, stay in DRAIN. The latest flush_pc wins.
REQ-016 An imem_ack received outside REQ and DRAIN SHALL be ignored.
REQ-017 Fetch is non-speculative: there SHALL be at most one outstanding request, and none while instr_valid=1.
REQ-018 Whenever instr_valid=0, Instruction SHALL equal NOP_INSTR.

Reset
REQ-019 While rst_n=0: PC=RESET_PC, state=RESET_WAIT, Instruction=NOP_INSTR, Opcode=6'b111111, pc_plus4=RESET_PC+4, instr_valid=0, imem_req=0, imem_addr=RESET_PC.
REQ-020 Reset mid-request SHALL abandon the request. The first post-reset ack is ignored unless it arrives in REQ.

Structure
REQ-021 Shared package SHALL hold the state encoding, NOP_INSTR, and the opcode field bounds (31:26).
REQ-022 One sub-module, next_pc_calc, SHALL be purely combinational and implement REQ-010.

Verification
REQ-023 Reset release with ack one cycle after each req: imem_addr sequence is 0, 4, 8; instr_valid pulses once per fetch.
REQ-024 Present Jump=1 with Instruction[25:0]=26'h000_0010 at pc_plus4=32'h0000_0008: the next imem_addr is 32'h0000_0040.
REQ-025 Branch=1, cond=1, imm=16'hFFFE, pc_plus4=32'h0000_0010: the next address is 32'h0000_0008. Same with cond=0: 32'h0000_0010.
REQ-026 stall=1 for 5 cycles in VALID: Instruction and instr_valid hold, and imem_req stays 0.
REQ-027 flush with flush_pc=32'h0000_0100 while a request is outstanding, ack 3 cycles later: the ack data is discarded and the next request address is 32'h0000_0100.
REQ-028 rst_n pulsed low mid-REQ: outputs match REQ-019 immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    REQ        = 2'd1,
    VALID      = 2'd2,
    DRAIN      = 2'd3
  } if_state_e;

  // Bubble word; opcode 6'b111111 decodes to all-zero controls.
  localparam logic [31:0] IF_NOP_INSTR = 32'hFC00_0000;

  // Opcode field bounds within an instruction word.
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
module next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] instr_index_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        cond_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;

  // Candidate targets; the branch immediate is the low 16 bits of the index field.
  always_comb begin
    jump_target   = {pc_plus4_i[31:28], instr_index_i, 2'b00};
    branch_offset = {{14{instr_index_i[15]}}, instr_index_i[15:0], 2'b00};
    branch_target = pc_plus4_i + branch_offset;
  end

  // Jump beats a taken branch, which beats fall-through.
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i) begin
      next_pc_o = jump_target;
    end else if (branch_i && cond_i) begin
      next_pc_o = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Non-speculative single-outstanding instruction fetch stage.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        cond,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [5:0]  Opcode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic [31:0] next_pc;

  next_pc_calc u_next_pc (
    .pc_plus4_i    (pcp4_q),
    .instr_index_i (instr_q[25:0]),
    .jump_i        (Jump),
    .branch_i      (Branch),
    .cond_i        (cond),
    .next_pc_o     (next_pc)
  );

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_WAIT;
      pc_q    <= word_align(RESET_PC);
      instr_q <= NOP_INSTR;
      pcp4_q  <= word_align(RESET_PC) + 32'd4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
    end
  end

  // Next-state and datapath update; flush has priority over ack and stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    unique case (state_q)
      RESET_WAIT: begin
        state_d = REQ;
        if (flush) begin
          pc_d    = word_align(flush_pc);
          instr_d = NOP_INSTR;
        end
      end
      REQ: begin
        if (flush) begin
          pc_d    = word_align(flush_pc);
          // A same-cycle ack retires the request, so no drain is needed.
          state_d = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          pcp4_d  = pc_q + 32'd4;
          state_d = VALID;
        end
      end
      VALID: begin
        if (flush) begin
          pc_d    = word_align(flush_pc);
          instr_d = NOP_INSTR;
          state_d = REQ;
        end else if (!stall) begin
          pc_d    = word_align(next_pc);
          instr_d = NOP_INSTR;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (flush) begin
          pc_d = word_align(flush_pc);
        end
        // Leaving on the stale ack even when a re-flush coincides, otherwise
        // the stage would wait for a response that never comes.
        if (imem_ack) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = RESET_WAIT;
      end
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    imem_req    = (state_q == REQ);
    instr_valid = (state_q == VALID);
    imem_addr   = pc_q;
    Instruction = instr_q;
    Opcode      = instr_q[OPC_MSB:OPC_LSB];
    pc_plus4    = pcp4_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        Branch;
  logic        Jump;
  logic        cond;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [5:0]  Opcode;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'hFC00_0000;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'hFC00_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .Branch      (Branch),
    .Jump        (Jump),
    .cond        (cond),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .Opcode      (Opcode),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   {31'd0, imem_req},    32'd0);
    check({tag, ".addr"},  imem_addr,            32'h0000_0000);
    check({tag, ".instr"}, Instruction,          NOP);
    check({tag, ".opc"},   {26'd0, Opcode},      32'h0000_003F);
    check({tag, ".pcp4"},  pc_plus4,             32'h0000_0004);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd0);
  endtask

  // From REQ: idle one cycle, ack with word, land in VALID and check the capture.
  task automatic fetch(input logic [31:0] addr_exp, input logic [31:0] word);
    logic [31:0] w;
    w = word;
    check("fetch.req",  {31'd0, imem_req}, 32'd1);
    check("fetch.addr", imem_addr, addr_exp);
    cyc();
    imem_ack   = 1'b1;
    imem_rdata = w;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("fetch.valid", {31'd0, instr_valid}, 32'd1);
    check("fetch.instr", Instruction, w);
    check("fetch.opc",   {26'd0, Opcode}, {26'd0, w[31:26]});
    check("fetch.pcp4",  pc_plus4, addr_exp + 32'd4);
    check("fetch.noreq", {31'd0, imem_req}, 32'd0);
  endtask

  // From VALID: consume with the given controls and check the next request address.
  task automatic consume(input logic j, input logic b, input logic c, input logic [31:0] next_exp);
    Jump   = j;
    Branch = b;
    cond   = c;
    stall  = 1'b0;
    cyc();
    Jump   = 1'b0;
    Branch = 1'b0;
    cond   = 1'b0;
    check("cons.valid", {31'd0, instr_valid}, 32'd0);
    check("cons.instr", Instruction, NOP);
    check("cons.req",   {31'd0, imem_req}, 32'd1);
    check("cons.addr",  imem_addr, next_exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    flush_pc   = 32'h0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    cond       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    cyc();
    cyc();
    check_reset_outputs("rst");

    // Release reset; an ack during RESET_WAIT must be ignored.
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rw.req", {31'd0, imem_req}, 32'd0);
    cyc();
    imem_ack   = 1'b0;
    check("rw.valid", {31'd0, instr_valid}, 32'd0);
    check("rw.instr", Instruction, NOP);

    // Sequential fetches 0, 4, 8.
    fetch(32'h0000_0000, 32'h2001_0001);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_0004);
    fetch(32'h0000_0004, 32'h2002_0002);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetch(32'h0000_0008, 32'h2003_0003);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_000C);

    // Flush with a request outstanding; the ack three cycles later is dropped.
    flush    = 1'b1;
    flush_pc = 32'h0000_0100;
    cyc();
    flush    = 1'b0;
    check("drain.req",  {31'd0, imem_req}, 32'd0);
    check("drain.addr", imem_addr, 32'h0000_0100);
    cyc();
    check("drain.req2", {31'd0, imem_req}, 32'd0);
    cyc();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    cyc();
    imem_ack   = 1'b0;
    check("drain.valid", {31'd0, instr_valid}, 32'd0);
    check("drain.instr", Instruction, NOP);
    fetch(32'h0000_0100, 32'h0000_0020);

    // Stall for five cycles; a stray ack in VALID must not disturb anything.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
      end
      cyc();
      imem_ack = 1'b0;
      check("stall.valid", {31'd0, instr_valid}, 32'd1);
      check("stall.instr", Instruction, 32'h0000_0020);
      check("stall.req",   {31'd0, imem_req}, 32'd0);
    end

    // Flush overrides stall; low address bits are dropped.
    flush    = 1'b1;
    flush_pc = 32'h0000_0007;
    cyc();
    flush = 1'b0;
    stall = 1'b0;
    check("vflush.valid", {31'd0, instr_valid}, 32'd0);
    check("vflush.instr", Instruction, NOP);

    // Jump wins over a taken branch: target 0x40, not 0x48.
    fetch(32'h0000_0004, 32'h0800_0010);
    consume(1'b1, 1'b1, 1'b1, 32'h0000_0040);

    // Flush coinciding with ack in REQ: data discarded, restart immediately.
    flush      = 1'b1;
    flush_pc   = 32'h0000_000C;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_DEAD;
    cyc();
    flush    = 1'b0;
    imem_ack = 1'b0;
    check("fack.valid", {31'd0, instr_valid}, 32'd0);
    check("fack.instr", Instruction, NOP);

    // Taken backward branch, then the same branch not taken.
    fetch(32'h0000_000C, 32'h1000_FFFE);
    consume(1'b0, 1'b1, 1'b1, 32'h0000_0008);
    fetch(32'h0000_0008, 32'h2004_0004);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_000C);
    fetch(32'h0000_000C, 32'h1000_FFFE);
    consume(1'b0, 1'b1, 1'b0, 32'h0000_0010);

    // Re-flush while draining: the latest flush_pc is used.
    flush    = 1'b1;
    flush_pc = 32'h0000_0200;
    cyc();
    flush_pc = 32'h0000_0300;
    cyc();
    flush    = 1'b0;
    check("reflush.req",  {31'd0, imem_req}, 32'd0);
    check("reflush.addr", imem_addr, 32'h0000_0300);
    imem_ack = 1'b1;
    cyc();
    imem_ack = 1'b0;

    // PC wrap at the top of the address space.
    fetch(32'h0000_0300, 32'h2005_0005);
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    cyc();
    flush = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h2006_0006);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_0000);

    // Reset asserted mid-request takes effect without a clock edge.
    fetch(32'h0000_0000, 32'h2007_0007);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_0004);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cyc();
    rst_n = 1'b1;
    #1;
    check("midrst.rw", {31'd0, imem_req}, 32'd0);
    cyc();
    fetch(32'h0000_0000, 32'h2008_0008);
    consume(1'b0, 1'b0, 1'b0, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
